// File: rtl/can_err_frame_pkg.sv
// Shared state encoding, default frame timing and a small helper for the
// CAN error/overload frame generator.
package can_err_frame_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ACT_FLAG = 3'd1,
    PAS_FLAG = 3'd2,
    WAIT_REC = 3'd3,
    DELIM    = 3'd4
  } err_state_e;

  localparam int CNT_W           = 4;
  localparam int DEF_FLAG_LEN    = 6;
  localparam int DEF_DELIM_LEN   = 8;
  localparam int DEF_DOM_SEQ_LEN = 8;

  // Any of the five detector error pulses.
  function automatic logic any_error(input logic [4:0] i_errs);
    return |i_errs;
  endfunction

endpackage

// File: rtl/can_error_frame_gen.sv
// CAN error / overload frame generator. Runs at bit rate: every transition and
// every tx_bit change happens on a clk edge qualified by sample_point. Produces
// the feedback pulses (dominant after flag, 8-dominant sequences) consumed by
// the error counters, plus delimiter-violation and frame-complete pulses.
module can_error_frame_gen
  import can_err_frame_pkg::*;
#(
  parameter int FLAG_LEN    = DEF_FLAG_LEN,
  parameter int DELIM_LEN   = DEF_DELIM_LEN,
  parameter int DOM_SEQ_LEN = DEF_DOM_SEQ_LEN
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_sample_point,
  input  logic i_rx_bit,
  input  logic i_bit_error,
  input  logic i_stuff_error,
  input  logic i_crc_error,
  input  logic i_form_error,
  input  logic i_ack_error,
  input  logic i_error_passive,
  input  logic i_bus_off,
  input  logic i_overload_request,
  output logic o_tx_bit,
  output logic o_tx_active,
  output logic o_err_frame_busy,
  output logic o_is_overload,
  output logic o_dominant_after_flag,
  output logic o_dom_seq,
  output logic o_delim_error,
  output logic o_frame_done
);

  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] FLAG_END  = CNT_W'(FLAG_LEN);
  localparam logic [CNT_W-1:0] EQ_END    = CNT_W'(FLAG_LEN - 1);
  localparam logic [CNT_W-1:0] DELIM_END = CNT_W'(DELIM_LEN - 1);
  localparam logic [CNT_W-1:0] DOM_END   = CNT_W'(DOM_SEQ_LEN - 1);

  err_state_e       r_state, w_state;
  logic [CNT_W-1:0] r_bit_cnt, w_bit_cnt;
  logic [CNT_W-1:0] r_eq_cnt, w_eq_cnt;
  logic [CNT_W-1:0] r_dom_cnt, w_dom_cnt;
  logic [CNT_W-1:0] r_delim_cnt, w_delim_cnt;
  logic r_last, w_last;
  logic r_first, w_first;
  logic r_pending, w_pending;
  logic r_is_overload, w_is_overload;
  logic r_tx_bit, w_tx_bit;
  logic r_tx_active, w_tx_active;
  logic r_busy;
  logic r_dom_after_flag, w_dom_after_flag;
  logic r_dom_seq, w_dom_seq;
  logic r_delim_error, w_delim_error;
  logic r_frame_done, w_frame_done;
  logic w_err_any;

  assign w_err_any = any_error({i_bit_error, i_stuff_error, i_crc_error,
                                i_form_error, i_ack_error});

  // Next-state, counter and output decode; pulses default low every clk.
  always_comb begin
    w_state          = r_state;
    w_bit_cnt        = r_bit_cnt;
    w_eq_cnt         = r_eq_cnt;
    w_dom_cnt        = r_dom_cnt;
    w_delim_cnt      = r_delim_cnt;
    w_last           = r_last;
    w_first          = r_first;
    w_pending        = r_pending;
    w_is_overload    = r_is_overload;
    w_tx_bit         = r_tx_bit;
    w_tx_active      = r_tx_active;
    w_dom_after_flag = 1'b0;
    w_dom_seq        = 1'b0;
    w_delim_error    = 1'b0;
    w_frame_done     = 1'b0;
    if (i_bus_off) begin
      // Bus-off silences the node and forgets anything in flight.
      w_state       = IDLE;
      w_tx_bit      = 1'b1;
      w_tx_active   = 1'b0;
      w_pending     = 1'b0;
      w_is_overload = 1'b0;
      w_first       = 1'b0;
      w_last        = 1'b0;
      w_bit_cnt     = CNT_ZERO;
      w_eq_cnt      = CNT_ZERO;
      w_dom_cnt     = CNT_ZERO;
      w_delim_cnt   = CNT_ZERO;
    end else if (!i_sample_point) begin
      // Between sample points only an error seen while idle is remembered.
      if (r_state == IDLE) begin
        w_pending = r_pending | w_err_any;
      end else begin
        w_pending = r_pending;
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (w_err_any | r_pending) begin
            w_pending     = 1'b0;
            w_is_overload = 1'b0;
            if (i_error_passive) begin
              w_state     = PAS_FLAG;
              w_tx_bit    = 1'b1;
              w_tx_active = 1'b0;
              w_eq_cnt    = CNT_ONE;
              w_last      = i_rx_bit;
            end else begin
              w_state     = ACT_FLAG;
              w_tx_bit    = 1'b0;
              w_tx_active = 1'b1;
              w_bit_cnt   = CNT_ONE;
            end
          end else if (i_overload_request) begin
            w_state       = ACT_FLAG;
            w_is_overload = 1'b1;
            w_tx_bit      = 1'b0;
            w_tx_active   = 1'b1;
            w_bit_cnt     = CNT_ONE;
          end else begin
            w_state = IDLE;
          end
        end
        ACT_FLAG: begin
          if (r_bit_cnt == FLAG_END) begin
            w_state     = WAIT_REC;
            w_tx_bit    = 1'b1;
            w_tx_active = 1'b0;
            w_first     = 1'b1;
            w_dom_cnt   = CNT_ZERO;
          end else begin
            w_bit_cnt = r_bit_cnt + CNT_ONE;
          end
        end
        PAS_FLAG: begin
          // A passive flag completes once FLAG_LEN equal bus bits are seen.
          if (i_rx_bit != r_last) begin
            w_eq_cnt = CNT_ONE;
            w_last   = i_rx_bit;
          end else if (r_eq_cnt == EQ_END) begin
            w_state   = WAIT_REC;
            w_first   = 1'b1;
            w_dom_cnt = CNT_ZERO;
          end else begin
            w_eq_cnt = r_eq_cnt + CNT_ONE;
          end
        end
        WAIT_REC: begin
          if (i_rx_bit) begin
            w_state     = DELIM;
            w_delim_cnt = CNT_ONE;
            w_first     = 1'b0;
          end else begin
            w_dom_after_flag = r_first & ~r_is_overload;
            w_first          = 1'b0;
            if (r_dom_cnt == DOM_END) begin
              w_dom_seq = 1'b1;
              w_dom_cnt = CNT_ZERO;
            end else begin
              w_dom_cnt = r_dom_cnt + CNT_ONE;
            end
          end
        end
        DELIM: begin
          if (!i_rx_bit) begin
            // Dominant inside the delimiter restarts with an error flag at once.
            w_delim_error = 1'b1;
            w_delim_cnt   = CNT_ZERO;
            w_pending     = 1'b0;
            w_is_overload = 1'b0;
            if (i_error_passive) begin
              w_state     = PAS_FLAG;
              w_tx_bit    = 1'b1;
              w_tx_active = 1'b0;
              w_eq_cnt    = CNT_ONE;
              w_last      = i_rx_bit;
            end else begin
              w_state     = ACT_FLAG;
              w_tx_bit    = 1'b0;
              w_tx_active = 1'b1;
              w_bit_cnt   = CNT_ONE;
            end
          end else if (r_delim_cnt == DELIM_END) begin
            w_state       = IDLE;
            w_frame_done  = 1'b1;
            w_is_overload = 1'b0;
            w_delim_cnt   = CNT_ZERO;
          end else begin
            w_delim_cnt = r_delim_cnt + CNT_ONE;
          end
        end
        default: begin
          w_state     = IDLE;
          w_tx_bit    = 1'b1;
          w_tx_active = 1'b0;
        end
      endcase
    end
  end

  // State, counter and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state          <= IDLE;
      r_bit_cnt        <= CNT_ZERO;
      r_eq_cnt         <= CNT_ZERO;
      r_dom_cnt        <= CNT_ZERO;
      r_delim_cnt      <= CNT_ZERO;
      r_last           <= 1'b0;
      r_first          <= 1'b0;
      r_pending        <= 1'b0;
      r_is_overload    <= 1'b0;
      r_tx_bit         <= 1'b1;
      r_tx_active      <= 1'b0;
      r_busy           <= 1'b0;
      r_dom_after_flag <= 1'b0;
      r_dom_seq        <= 1'b0;
      r_delim_error    <= 1'b0;
      r_frame_done     <= 1'b0;
    end else begin
      r_state          <= w_state;
      r_bit_cnt        <= w_bit_cnt;
      r_eq_cnt         <= w_eq_cnt;
      r_dom_cnt        <= w_dom_cnt;
      r_delim_cnt      <= w_delim_cnt;
      r_last           <= w_last;
      r_first          <= w_first;
      r_pending        <= w_pending;
      r_is_overload    <= w_is_overload;
      r_tx_bit         <= w_tx_bit;
      r_tx_active      <= w_tx_active;
      r_busy           <= (w_state != IDLE);
      r_dom_after_flag <= w_dom_after_flag;
      r_dom_seq        <= w_dom_seq;
      r_delim_error    <= w_delim_error;
      r_frame_done     <= w_frame_done;
    end
  end

  assign o_tx_bit              = r_tx_bit;
  assign o_tx_active           = r_tx_active;
  assign o_err_frame_busy      = r_busy;
  assign o_is_overload         = r_is_overload;
  assign o_dominant_after_flag = r_dom_after_flag;
  assign o_dom_seq             = r_dom_seq;
  assign o_delim_error         = r_delim_error;
  assign o_frame_done          = r_frame_done;

endmodule

// File: tb/tb_can_error_frame_gen.sv
// Bench for can_error_frame_gen: directed scenarios followed by randomized bus
// traffic. A behavioural model predicts all outputs each clk and queues them;
// an independent monitor pops and compares after every clk edge.
module tb_can_error_frame_gen;

  localparam int FLAG_LEN    = 6;
  localparam int DELIM_LEN   = 8;
  localparam int DOM_SEQ_LEN = 8;

  localparam int PH_IDLE  = 0;
  localparam int PH_AFLAG = 1;
  localparam int PH_PFLAG = 2;
  localparam int PH_WAIT  = 3;
  localparam int PH_DELIM = 4;

  logic clk = 1'b0;
  logic rst, sp, rx, be, se, ce, fe, ae, ep, bo, ovr;
  logic o_tx_bit, o_tx_active, o_busy, o_is_ovl, o_daf, o_dseq, o_derr, o_done;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  // Reference model state (spec-level view of the frame).
  int   m_phase, m_flag_left, m_run_len, m_dom_run, m_rec_seen;
  logic m_run_lvl, m_after_flag, m_pending, m_ovl, m_tx, m_txa;
  logic p_daf, p_dseq, p_derr, p_done;

  always #5 clk = ~clk;

  can_error_frame_gen dut (
    .i_clk(clk), .i_rst(rst), .i_sample_point(sp), .i_rx_bit(rx),
    .i_bit_error(be), .i_stuff_error(se), .i_crc_error(ce),
    .i_form_error(fe), .i_ack_error(ae), .i_error_passive(ep),
    .i_bus_off(bo), .i_overload_request(ovr),
    .o_tx_bit(o_tx_bit), .o_tx_active(o_tx_active),
    .o_err_frame_busy(o_busy), .o_is_overload(o_is_ovl),
    .o_dominant_after_flag(o_daf), .o_dom_seq(o_dseq),
    .o_delim_error(o_derr), .o_frame_done(o_done)
  );

  task automatic m_reset();
    m_phase = PH_IDLE; m_flag_left = 0; m_run_len = 0; m_dom_run = 0;
    m_rec_seen = 0; m_run_lvl = 1'b0; m_after_flag = 1'b0;
    m_pending = 1'b0; m_ovl = 1'b0; m_tx = 1'b1; m_txa = 1'b0;
  endtask

  task automatic m_start_error();
    m_pending = 1'b0;
    m_ovl     = 1'b0;
    if (ep) begin
      m_phase = PH_PFLAG; m_tx = 1'b1; m_txa = 1'b0;
      m_run_lvl = rx; m_run_len = 1;
    end else begin
      m_phase = PH_AFLAG; m_tx = 1'b0; m_txa = 1'b1;
      m_flag_left = FLAG_LEN;
    end
  endtask

  // Predict the outputs after the coming edge from the inputs now applied.
  task automatic model_step();
    logic err;
    err = be | se | ce | fe | ae;
    p_daf = 1'b0; p_dseq = 1'b0; p_derr = 1'b0; p_done = 1'b0;
    if (rst) begin
      m_reset();
    end else if (bo) begin
      m_reset();
    end else if (m_phase == PH_IDLE) begin
      if (!sp) m_pending = m_pending | err;
      else if (err || m_pending) m_start_error();
      else if (ovr) begin
        m_phase = PH_AFLAG; m_ovl = 1'b1; m_tx = 1'b0; m_txa = 1'b1;
        m_flag_left = FLAG_LEN;
      end
    end else if (sp) begin
      case (m_phase)
        PH_AFLAG: begin
          m_flag_left--;
          if (m_flag_left == 0) begin
            m_phase = PH_WAIT; m_tx = 1'b1; m_txa = 1'b0;
            m_after_flag = 1'b1; m_dom_run = 0;
          end
        end
        PH_PFLAG: begin
          if (rx == m_run_lvl) m_run_len++;
          else begin m_run_lvl = rx; m_run_len = 1; end
          if (m_run_len >= FLAG_LEN) begin
            m_phase = PH_WAIT; m_after_flag = 1'b1; m_dom_run = 0;
          end
        end
        PH_WAIT: begin
          if (rx) begin
            m_phase = PH_DELIM; m_rec_seen = 1; m_after_flag = 1'b0;
          end else begin
            if (m_after_flag && !m_ovl) p_daf = 1'b1;
            m_after_flag = 1'b0;
            m_dom_run++;
            if (m_dom_run % DOM_SEQ_LEN == 0) p_dseq = 1'b1;
          end
        end
        PH_DELIM: begin
          if (!rx) begin
            p_derr = 1'b1;
            m_start_error();
          end else begin
            m_rec_seen++;
            if (m_rec_seen == DELIM_LEN) begin
              m_phase = PH_IDLE; p_done = 1'b1; m_ovl = 1'b0;
            end
          end
        end
        default: m_phase = PH_IDLE;
      endcase
    end
  endtask

  // One clk: predict, queue the prediction, let the edge happen. Called at negedge.
  task automatic tick();
    model_step();
    exp_q.push_back({m_tx, m_txa, (m_phase != PH_IDLE), m_ovl,
                     p_daf, p_dseq, p_derr, p_done});
    @(posedge clk);
    @(negedge clk);
  endtask

  // One bus bit of div clks, sample point on the last; optional error pulse at clk ek.
  task automatic run_bit(input logic rxv, input int div, input int ek, input logic [4:0] em);
    rx = rxv;
    for (int k = 0; k < div; k++) begin
      sp = (k == div - 1);
      {be, se, ce, fe, ae} = (k == ek) ? em : 5'b00000;
      tick();
    end
    sp = 1'b0;
    {be, se, ce, fe, ae} = 5'b00000;
  endtask

  // n bits where the bus follows our own tx, optionally overdriven dominant.
  task automatic run_follow(input int n, input logic force_dom);
    for (int i = 0; i < n; i++) run_bit(m_tx & ~force_dom, 3, -1, 5'b00000);
  endtask

  task automatic pulse_err(input logic [4:0] em);
    sp = 1'b0;
    {be, se, ce, fe, ae} = em;
    tick();
    {be, se, ce, fe, ae} = 5'b00000;
  endtask

  // Monitor: compare every output after each clk edge against the queued prediction.
  always @(posedge clk) begin
    logic [7:0] exp_v, act_v;
    #1;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      act_v = {o_tx_bit, o_tx_active, o_busy, o_is_ovl, o_daf, o_dseq, o_derr, o_done};
      n_cmp++;
      if (act_v !== exp_v) begin
        n_err++;
        $display("FAIL outputs t=%0t tx/txa/busy/ovl/daf/dseq/derr/done got %b want %b",
                 $time, act_v, exp_v);
      end
    end
  end

  initial begin
    int div, ek, bo_left, dom_left;
    logic [4:0] em;
    rst = 1'b1; sp = 1'b0; rx = 1'b1; {be, se, ce, fe, ae} = 5'b00000;
    ep = 1'b0; bo = 1'b0; ovr = 1'b0;
    m_reset();
    @(negedge clk);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Active error frame, bus follows us.
    pulse_err(5'b10000);
    run_follow(20, 1'b0);
    // Passive error frame on a recessive bus.
    ep = 1'b1;
    pulse_err(5'b00100);
    run_follow(20, 1'b0);
    ep = 1'b0;
    // Dominant bus for 16 bits after the flag.
    pulse_err(5'b10000);
    run_follow(7, 1'b0);
    run_follow(16, 1'b1);
    run_follow(10, 1'b0);
    // Dominant at delimiter bit 4.
    pulse_err(5'b00010);
    run_follow(7, 1'b0);
    run_follow(3, 1'b0);
    run_follow(1, 1'b1);
    run_follow(20, 1'b0);
    // Overload alone, then dominant bus after its flag.
    ovr = 1'b1;
    run_follow(1, 1'b0);
    ovr = 1'b0;
    run_follow(6, 1'b0);
    run_follow(3, 1'b1);
    run_follow(12, 1'b0);
    // Overload together with a stuff error: error wins.
    ovr = 1'b1;
    run_bit(1'b1, 3, 2, 5'b01000);
    ovr = 1'b0;
    run_follow(20, 1'b0);
    // Bus-off in active flag bit 3, errors while bus-off are dropped.
    pulse_err(5'b10000);
    run_follow(3, 1'b0);
    bo = 1'b1;
    tick();
    pulse_err(5'b11111);
    run_follow(4, 1'b0);
    bo = 1'b0;
    run_follow(4, 1'b0);
    // Reset in the middle of the delimiter.
    pulse_err(5'b00001);
    run_follow(10, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    run_follow(4, 1'b0);

    // Randomized traffic.
    bo_left = 0; dom_left = 0;
    for (int b = 0; b < 600; b++) begin
      div = $urandom_range(1, 4);
      ek  = ($urandom_range(0, 99) < 6) ? $urandom_range(0, div - 1) : -1;
      em  = 5'b00001 << $urandom_range(0, 4);
      if ($urandom_range(0, 99) < 5) ovr = ~ovr;
      if ($urandom_range(0, 99) < 8) ep = ~ep;
      if (bo_left > 0) bo_left--;
      else if ($urandom_range(0, 199) < 2) bo_left = $urandom_range(1, 3);
      bo = (bo_left > 0);
      if (dom_left > 0) dom_left--;
      else if ($urandom_range(0, 99) < 8) dom_left = $urandom_range(1, 18);
      run_bit(m_tx & (dom_left == 0), div, ek, em);
    end
    bo = 1'b0; ovr = 1'b0;
    run_follow(30, 1'b0);

    for (int w = 0; w < 10 && exp_q.size() != 0; w++) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d predictions left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/can_error_frame_gen.md
Name: can_error_frame_gen

Overview:
- Downstream of can_error_detection: consumes its error pulses and confinement state (error_passive, bus_off).
- Generates the error frame or overload frame on the transmit path: flag, superposition wait, delimiter.
- Produces dominant_after_flag and 8-dominant-sequence pulses that feed back into can_error_detection for TEC/REC updates.
- Bit-rate block: all state advances only on sample_point strobes from bit timing.

Parameters:
- FLAG_LEN, 6, error/overload flag length in bits.
- DELIM_LEN, 8, delimiter length in recessive bits, including the first recessive bit detected.
- DOM_SEQ_LEN, 8, consecutive dominant bits after the flag that produce one dom_seq pulse.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- sample_point  in  1  one-clk strobe at the bit sample instant
- rx_bit  in  1  sampled bus level (0 = dominant)
- bit_error, stuff_error, crc_error, form_error, ack_error  in  1 each  error pulses from can_error_detection
- error_passive  in  1  node is error-passive
- bus_off  in  1  node is bus-off
- overload_request  in  1  MAC requests an overload frame (level, sampled at sample_point)
- tx_bit  out  1  bit to transmitter, 1 = recessive
- tx_active  out  1  high while driving dominant flag bits (enables bit check)
- err_frame_busy  out  1  high in any state except IDLE
- is_overload  out  1  current frame is an overload frame
- dominant_after_flag  out  1  one-clk pulse: first bit after own flag was dominant
- dom_seq  out  1  one-clk pulse per DOM_SEQ_LEN dominant bits after the flag
- delim_error  out  1  one-clk pulse: dominant bit sampled inside the delimiter
- frame_done  out  1  one-clk pulse: delimiter completed

Behaviour:
- Reset values: state IDLE; tx_bit=1; all other outputs 0; counters 0; pending 0.
- err_any is the OR of the five error inputs. It sets pending on any clk. pending clears when a flag starts.
- All transitions and tx_bit updates occur on the clk edge where sample_point=1. tx_bit then holds until the next sample_point.
- IDLE, on (pending | err_any):
  - error_passive=0: go to ACT_FLAG, tx_bit=0, tx_active=1, bit_cnt=1.
  - error_passive=1: go to PAS_FLAG, tx_bit=1, eq_cnt=1, last=rx_bit.
- IDLE, otherwise, on overload_request=1: go to ACT_FLAG with is_overload=1. Error has priority over overload when both are present.
- ACT_FLAG: if bit_cnt==FLAG_LEN, go to WAIT_REC with tx_bit=1, tx_active=0, first=1, dom_cnt=0. Else bit_cnt++.
- PAS_FLAG tracks equal consecutive rx bits:
  - rx_bit==last: eq_cnt++.
  - else: eq_cnt=1, last=rx_bit.
  - eq_cnt reaching FLAG_LEN: go to WAIT_REC with first=1.
- WAIT_REC:
  - rx_bit=1: go to DELIM, delim_cnt=1, first=0.
  - rx_bit=0 and first=1: pulse dominant_after_flag (error frames only, not overload).
  - rx_bit=0: first=0; dom_cnt++. When dom_cnt reaches DOM_SEQ_LEN, pulse dom_seq and reset dom_cnt to 0; this repeats every 8.
- DELIM:
  - rx_bit=0: pulse delim_error, set pending, go to IDLE-equivalent restart. The flag starts on the same edge, following the IDLE rules with pending=1.
  - rx_bit=1 and delim_cnt==DELIM_LEN-1: go to IDLE, pulse frame_done, is_overload=0.
  - rx_bit=1 otherwise: delim_cnt++.
- Errors arriving in ACT_FLAG, PAS_FLAG, WAIT_REC or DELIM are ignored and do not set pending. The one exception is delim_error as above.
- bus_off=1 on any clk:
  - Forces IDLE, tx_bit=1, tx_active=0.
  - Clears pending and counters; no frame_done.
  - Held while bus_off=1.
- error_passive changing mid-flag has no effect until the next flag.
- rst mid-frame returns to reset values on the next edge.
- Pulses are exactly 1 clk wide, aligned with the sample_point edge.

Decomposition:
- can_err_frame_pkg: state enum {IDLE, ACT_FLAG, PAS_FLAG, WAIT_REC, DELIM} and the default constants for FLAG_LEN, DELIM_LEN and DOM_SEQ_LEN.
- Counters are 4 bits wide.
- Single module; no sub-module warranted.

Test Plan:
- Active error: pulse bit_error, error_passive=0, rx_bit follows tx_bit.
  -> tx_bit=0 for 6 sample_points, tx_active=1.
  -> Then recessive for 8 bits, frame_done once, then IDLE.
- Passive error: error_passive=1, crc_error pulse, bus recessive.
  -> tx_bit stays 1; WAIT_REC after 6 equal bits; frame_done after 8 more bits.
- Dominant after flag: active flag, then rx_bit=0 for 16 bits, then recessive.
  -> dominant_after_flag once on bit 7; dom_seq pulses at 8 and 16 dominant bits; frame_done 8 bits after the first recessive.
- Delimiter violation: rx_bit=0 at delimiter bit 4.
  -> delim_error pulse; new 6-bit dominant flag starts on the same edge.
- Overload and priority:
  -> overload_request alone gives a 6-dominant flag with is_overload=1 and no dominant_after_flag.
  -> overload_request together with stuff_error gives an error frame with is_overload=0.
- bus_off and reset: bus_off asserted in ACT_FLAG bit 3.
  -> Next clk: tx_bit=1, tx_active=0, IDLE; errors are ignored while bus_off=1.
  -> rst mid-DELIM restores all reset values.
